// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with FIFO-buffered load results into
// one registered register-bank write per cycle. Optional R0_DISCARD_EN drops writes to r0.
module wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [3:0]  alu_dest,
   input  logic [15:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [3:0]  mem_dest,
   input  logic [15:0] mem_data,
   output logic        mem_ready,
   output logic [15:0] regEnable,
   output logic [15:0] ALUBus,
   output logic [15:0] mem_pending
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [3:0]    dest_q [DEPTH];
   logic [15:0]   data_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    starve_q, starve_d;
   logic [15:0]   reg_en_q, reg_en_d;
   logic [15:0]   bus_q, bus_d;

   logic          empty, force_pop, alu_fire, alu_wr, push, pop;
   logic          alu_drop, mem_drop;
   logic          sel_valid;
   logic [3:0]    sel_dest;
   logic [15:0]   sel_data;

`ifdef R0_DISCARD_EN
   assign alu_drop = (alu_dest == 4'd0);
   assign mem_drop = (mem_dest == 4'd0);
`else
   assign alu_drop = 1'b0;
   assign mem_drop = 1'b0;
`endif

   assign empty     = (count_q == '0);
   assign force_pop = !empty && (starve_q == 4'(STARVE_MAX));
   assign alu_ready = !reset && !force_pop;
   // Ready depends only on registered count, so a same-cycle pop never opens a full FIFO.
   assign mem_ready = !reset && (count_q < CW'(DEPTH));
   assign alu_fire  = alu_valid && alu_ready;
   assign alu_wr    = alu_fire && !alu_drop;
   assign push      = mem_valid && mem_ready && !mem_drop;
   assign pop       = !empty && (force_pop || !alu_valid);

   always_comb begin
      sel_valid = 1'b0;
      sel_dest  = alu_dest;
      sel_data  = alu_data;
      if (pop) begin
         sel_valid = 1'b1;
         sel_dest  = dest_q[rd_q];
         sel_data  = data_q[rd_q];
      end else if (alu_wr) begin
         sel_valid = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop || empty)
         starve_d = 4'd0;
      else if (alu_wr && (starve_q != 4'(STARVE_MAX)))
         starve_d = starve_q + 4'd1;
      else
         starve_d = starve_q;
      reg_en_d = sel_valid ? (16'h0001 << sel_dest) : 16'h0000;
      bus_d    = sel_valid ? sel_data : bus_q;
   end

   always_comb begin
      mem_pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if (CW'(i) < count_q)
            mem_pending[dest_q[rd_q + AW'(i)]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q     <= '0;
         wr_q     <= '0;
         count_q  <= '0;
         starve_q <= 4'd0;
         reg_en_q <= 16'h0000;
         bus_q    <= 16'h0000;
      end else begin
         rd_q     <= rd_q + AW'(pop);
         wr_q     <= wr_q + AW'(push);
         count_q  <= count_d;
         starve_q <= starve_d;
         reg_en_q <= reg_en_d;
         bus_q    <= bus_d;
      end
   end

   // Entry storage needs no reset: only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_q[wr_q] <= mem_dest;
         data_q[wr_q] <= mem_data;
      end
   end

   assign regEnable = reg_en_q;
   assign ALUBus    = bus_q;

endmodule
